perf_monitor: RTL and testbench
===============================

PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL provide parameter CNT_W, default 32, width of every event counter.
REQ-002 SHALL provide parameter IDLE_LIMIT, default 8, number of consecutive non-retiring RUN cycles that ends a run (legal range 2..255).
REQ-003 SHALL provide ports, clock and reset first:
- clk_i  input  1  sole clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  CPU start level; high requests a run
- clear_i  input  1  synchronous counter clear and return to IDLE
- stall_i  input  1  hazard-detection stall asserted this cycle
- flush_i  input  1  branch flush asserted this cycle
- branch_i  input  1  branch resolving in ID this cycle
- retire_i  input  1  non-bubble instruction leaving MEM/WB this cycle
- cycle_cnt_o  output  CNT_W  RUN cycles counted
- stall_cnt_o  output  CNT_W  qualified stall cycles
- flush_cnt_o  output  CNT_W  flush cycles
- retire_cnt_o  output  CNT_W  retired instructions
- state_o  output  2  00 IDLE, 01 RUN, 10 DONE
- running_o  output  1  high iff state is RUN
- done_o  output  1  one-cycle pulse on the first DONE cycle
REQ-004 SHALL use one clock; reset is synchronous and active-high (clk_i, rst_i).

Function
REQ-005 SHALL implement a three-state FSM: IDLE, RUN, DONE; encoding 11 unreachable, decoded as IDLE on the next edge.
REQ-006 IDLE->RUN SHALL occur on the edge where start_i=1 and clear_i=0; no counter increments on that edge.
REQ-007 In RUN, every edge SHALL increment cycle_cnt_o by 1.
REQ-008 In RUN, stall_cnt_o SHALL increment iff stall_i=1 and branch_i=0.
REQ-009 In RUN, flush_cnt_o SHALL increment iff flush_i=1; retire_cnt_o SHALL increment iff retire_i=1; events in the same cycle count independently.
REQ-010 Every counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-011 An internal idle counter SHALL clear on any RUN edge with retire_i=1 and increment on RUN edges with retire_i=0.
REQ-012 RUN->DONE SHALL occur on the edge completing IDLE_LIMIT consecutive RUN cycles with retire_i=0; that edge still updates all counters.
REQ-013 RUN->DONE SHALL also occur on any RUN edge with start_i=0; that edge still updates counters.
REQ-014 done_o SHALL be registered, high exactly in the first cycle state_o=10, low otherwise.
REQ-015 DONE SHALL hold all counters; start_i is ignored in DONE.
REQ-016 clear_i=1 SHALL, in any state, zero all counters and the idle counter and enter IDLE on that edge; clear_i outranks start_i and all events.
REQ-017 In IDLE all counters SHALL hold; events are ignored.
REQ-018 Outputs SHALL be driven directly from registers; no combinational input-to-output path.

Reset
REQ-019 rst_i=1 at an edge SHALL set state IDLE, all counters and idle counter 0, done_o 0, running_o 0, overriding clear_i and start_i.
REQ-020 rst_i asserted mid-RUN SHALL discard the run; counting resumes only after a new IDLE->RUN transition.

Verification
REQ-021 Reset then start_i=1, retire_i=1 for 10 cycles, then retire_i=0 -> RUN entered edge 1, retire_cnt=10, DONE after 8 further edges, cycle_cnt=18, done_o high one cycle.
REQ-022 In RUN, stall_i=1 for 4 cycles, branch_i=1 in 2 of them, flush_i=1 in 3 -> stall_cnt=2, flush_cnt=3.
REQ-023 CNT_W=4, retire_i=1 for 20 RUN cycles -> cycle_cnt and retire_cnt stop at 15, no wrap, no DONE.
REQ-024 start_i drops after 5 RUN cycles -> DONE on that edge, cycle_cnt=6; start_i re-asserted in DONE -> no change.
REQ-025 clear_i and start_i both high in DONE -> IDLE, counters 0; next edge with start_i=1 -> RUN.
REQ-026 rst_i for one edge at RUN cycle 7 -> state 00, counters 0, done_o never pulses.

Source files
------------

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: counts RUN cycles, qualified stalls, flushes and
// retirements between a CPU start and either a stop request or an idle timeout.
module perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int IDLE_LIMIT = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             branch_i,
    input  logic             retire_i,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [1:0]       state_o,
    output logic             running_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // The idle counter reaching IDLE_LAST with another non-retiring cycle ends the run.
    localparam logic [7:0]       IDLE_LAST = 8'(IDLE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [7:0]       idle_q, idle_d;
    logic             done_q, done_d;
    logic             running_q, running_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        cycle_d  = cycle_q;
        stall_d  = stall_q;
        flush_d  = flush_q;
        retire_d = retire_q;
        idle_d   = idle_q;
        done_d   = 1'b0;
        if (clear_i) begin
            state_d  = S_IDLE;
            cycle_d  = '0;
            stall_d  = '0;
            flush_d  = '0;
            retire_d = '0;
            idle_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_RUN;
                        idle_d  = '0;
                    end
                end
                S_RUN: begin
                    cycle_d  = sat_inc(cycle_q, 1'b1);
                    stall_d  = sat_inc(stall_q, stall_i && !branch_i);
                    flush_d  = sat_inc(flush_q, flush_i);
                    retire_d = sat_inc(retire_q, retire_i);
                    idle_d   = retire_i ? 8'd0 : idle_q + 8'd1;
                    if ((!retire_i && (idle_q == IDLE_LAST)) || !start_i) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cycle_q   <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            retire_q  <= '0;
            idle_q    <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            retire_q  <= retire_d;
            idle_q    <= idle_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign cycle_cnt_o  = cycle_q;
    assign stall_cnt_o  = stall_q;
    assign flush_cnt_o  = flush_q;
    assign retire_cnt_o = retire_q;
    assign state_o      = state_q;
    assign running_o    = running_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: a wide (32-bit) and a narrow (4-bit) instance share stimulus
// and are scored every cycle against a count-based reference model.
module tb_perf_monitor;

    localparam int LIMIT = 8;

    logic clk;
    logic rst, start, clear, stall, flush, branch, retire;

    logic [31:0] w_cyc, w_stl, w_fls, w_ret;
    logic [1:0]  w_state;
    logic        w_run, w_done;
    logic [3:0]  n_cyc, n_stl, n_fls, n_ret;
    logic [1:0]  n_state;
    logic        n_run, n_done;

    perf_monitor #(.CNT_W(32), .IDLE_LIMIT(LIMIT)) u_dut_w (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .stall_i(stall), .flush_i(flush), .branch_i(branch), .retire_i(retire),
        .cycle_cnt_o(w_cyc), .stall_cnt_o(w_stl), .flush_cnt_o(w_fls), .retire_cnt_o(w_ret),
        .state_o(w_state), .running_o(w_run), .done_o(w_done)
    );

    perf_monitor #(.CNT_W(4), .IDLE_LIMIT(LIMIT)) u_dut_n (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .stall_i(stall), .flush_i(flush), .branch_i(branch), .retire_i(retire),
        .cycle_cnt_o(n_cyc), .stall_cnt_o(n_stl), .flush_cnt_o(n_fls), .retire_cnt_o(n_ret),
        .state_o(n_state), .running_o(n_run), .done_o(n_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: raw event counts, saturation applied when comparing
    typedef struct {
        logic [1:0] st;
        logic       run;
        logic       dn;
        longint     cyc, stl, fls, ret;
    } exp_t;

    exp_t   exp_q[$];
    int     m_mode;   // 0 idle, 1 run, 2 done
    int     m_idle;
    logic   m_done;
    longint m_cyc, m_stl, m_fls, m_ret;

    int checks = 0;
    int errors = 0;

    task automatic model_step();
        exp_t e;
        m_done = 1'b0;
        if (rst || clear) begin
            m_mode = 0; m_idle = 0;
            m_cyc = 0; m_stl = 0; m_fls = 0; m_ret = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1;
                m_idle = 0;
            end
        end else if (m_mode == 1) begin
            m_cyc++;
            if (stall && !branch) m_stl++;
            if (flush) m_fls++;
            if (retire) m_ret++;
            m_idle = retire ? 0 : m_idle + 1;
            if (m_idle >= LIMIT || !start) begin
                m_mode = 2;
                m_done = 1'b1;
            end
        end
        e.st  = (m_mode == 1) ? 2'b01 : (m_mode == 2) ? 2'b10 : 2'b00;
        e.run = (m_mode == 1);
        e.dn  = m_done;
        e.cyc = m_cyc; e.stl = m_stl; e.fls = m_fls; e.ret = m_ret;
        exp_q.push_back(e);
    endtask

    // driver
    task automatic step(input logic r, input logic s, input logic c, input logic st,
                        input logic fl, input logic br, input logic re);
        @(negedge clk);
        rst = r; start = s; clear = c; stall = st; flush = fl; branch = br; retire = re;
        model_step();
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("w_state",   longint'(w_state), longint'(e.st));
                chk("w_running", longint'(w_run),   longint'(e.run));
                chk("w_done",    longint'(w_done),  longint'(e.dn));
                chk("w_cycle",   longint'(w_cyc),   sat(e.cyc, 64'hFFFF_FFFF));
                chk("w_stall",   longint'(w_stl),   sat(e.stl, 64'hFFFF_FFFF));
                chk("w_flush",   longint'(w_fls),   sat(e.fls, 64'hFFFF_FFFF));
                chk("w_retire",  longint'(w_ret),   sat(e.ret, 64'hFFFF_FFFF));
                chk("n_state",   longint'(n_state), longint'(e.st));
                chk("n_done",    longint'(n_done),  longint'(e.dn));
                chk("n_cycle",   longint'(n_cyc),   sat(e.cyc, 15));
                chk("n_stall",   longint'(n_stl),   sat(e.stl, 15));
                chk("n_flush",   longint'(n_fls),   sat(e.fls, 15));
                chk("n_retire",  longint'(n_ret),   sat(e.ret, 15));
                chk("n_running", longint'(n_run),   longint'(e.run));
            end
        end
    end

    initial begin
        int p;
        logic [3:0] br_pat, fl_pat;
        rst = 1'b1; start = 1'b0; clear = 1'b0;
        stall = 1'b0; flush = 1'b0; branch = 1'b0; retire = 1'b0;
        m_mode = 0; m_idle = 0; m_done = 1'b0;
        m_cyc = 0; m_stl = 0; m_fls = 0; m_ret = 0;

        // reset state
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // retire burst then idle timeout
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)  step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)  step(0, 1, 0, 1, 1, 0, 1);

        // stall qualification by branch, flushes
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        br_pat = 4'b0011;
        fl_pat = 4'b1101;
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, fl_pat[i], br_pat[i], 1);

        // saturation on the narrow instance, no DONE
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 1, 1, 0, 1);

        // start drop ends run, start ignored in DONE
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, 0, 1);

        // clear with start in DONE, then restart
        step(0, 1, 1, 1, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 0, 0, 1);

        // reset mid-run discards it
        step(1, 1, 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);

        // randomized traffic with varying retire density
        p = 70;
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 10;
                    1: p = 50;
                    default: p = 95;
                endcase
            end
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 92),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 99) < p));
        end

        // drain the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
